// File: rtl/fifo_async_level.sv
// fifo_async_level: dual-clock FIFO. The write side runs on i_clk and the
// read side on o_clk. Binary pointers are converted to Gray code and
// registered in their own domain before they cross through SYNC flops.
// The read side is first-word-fall-through with a registered output word.
// Define FIFO_ASYNC_LEVEL_EN to build the fill-level ports
// (i_level, i_afull, o_level, o_aempty). Without it those ports are tied to 0.
module fifo_async_level #(
    parameter int DW        = 8,
    parameter int EA        = 10,
    parameter int SYNC      = 2,
    parameter int AFULL_TH  = (1 << EA) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          o_clk,
    input  logic          o_rstn,
    output logic          i_tready,
    input  logic          i_tvalid,
    input  logic [DW-1:0] i_tdata,
    output logic [EA:0]   i_level,
    output logic          i_afull,
    input  logic          o_tready,
    output logic          o_tvalid,
    output logic [DW-1:0] o_tdata,
    output logic [EA:0]   o_level,
    output logic          o_aempty
);

    localparam int Depth = 1 << EA;

    function automatic logic [EA:0] bin2gray(input logic [EA:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [EA:0] gray2bin(input logic [EA:0] g);
        logic [EA:0] b;
        b[EA] = g[EA];
        for (int k = EA - 1; k >= 0; k--) begin
            b[k] = b[k + 1] ^ g[k];
        end
        return b;
    endfunction

    logic [DW-1:0] mem [Depth];

    logic [EA:0]   wrPtrBin_q;
    logic [EA:0]   wrPtrBin_d;
    logic [EA:0]   wrPtrGray_q;
    logic [EA:0]   rdGraySync_q [SYNC];
    logic [EA:0]   fullMatch;
    logic          full;
    logic          wrEn;

    logic [EA:0]   popPtrBin_q;
    logic [EA:0]   popPtrBin_d;
    logic [EA:0]   popPtrGray_q;
    logic [EA:0]   rdAddr_q;
    logic [EA:0]   rdAddr_d;
    logic [EA:0]   wrGraySync_q [SYNC];
    logic [EA:0]   wrSyncBin;
    logic          outValid_q;
    logic          outValid_d;
    logic [DW-1:0] outData_q;
    logic          pop;
    logic          load;
    logic          memHasData;

    // The FIFO is full when the write pointer is exactly one lap ahead of
    // the consumed pointer: the Gray images match with the two MSBs inverted.
    assign fullMatch  = {~rdGraySync_q[SYNC-1][EA:EA-1], rdGraySync_q[SYNC-1][EA-2:0]};
    assign full       = (wrPtrGray_q == fullMatch);
    assign i_tready   = ~full;
    assign wrEn       = i_tvalid & ~full;
    assign wrPtrBin_d = wrPtrBin_q + {{EA{1'b0}}, wrEn};

    // Advance the write pointer and keep its Gray image registered for the crossing
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wrPtrBin_q  <= '0;
            wrPtrGray_q <= '0;
        end else begin
            wrPtrBin_q  <= wrPtrBin_d;
            wrPtrGray_q <= bin2gray(wrPtrBin_d);
        end
    end

    // Bring the consumed (popped) pointer into the write clock domain
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < SYNC; k++) begin
                rdGraySync_q[k] <= '0;
            end
        end else begin
            rdGraySync_q[0] <= popPtrGray_q;
            for (int k = 1; k < SYNC; k++) begin
                rdGraySync_q[k] <= rdGraySync_q[k-1];
            end
        end
    end

    // Storage array, written only on accepted beats and never reset
    always_ff @(posedge i_clk) begin
        if (wrEn) begin
            mem[wrPtrBin_q[EA-1:0]] <= i_tdata;
        end
    end

    // rdAddr runs at most one word ahead of popPtr: that word sits in the
    // output register. Space is freed for the writer only when a word is popped,
    // so the capacity stays exactly Depth words.
    assign wrSyncBin   = gray2bin(wrGraySync_q[SYNC-1]);
    assign memHasData  = (rdAddr_q != wrSyncBin);
    assign pop         = outValid_q & o_tready;
    assign load        = memHasData & (~outValid_q | o_tready);
    assign popPtrBin_d = popPtrBin_q + {{EA{1'b0}}, pop};
    assign rdAddr_d    = rdAddr_q + {{EA{1'b0}}, load};

    // Output-valid next state: a fresh load wins over a pop that empties the register
    always_comb begin
        outValid_d = outValid_q;
        if (load) begin
            outValid_d = 1'b1;
        end else if (pop) begin
            outValid_d = 1'b0;
        end
    end

    // Bring the write pointer into the read clock domain
    always_ff @(posedge o_clk or negedge o_rstn) begin
        if (!o_rstn) begin
            for (int k = 0; k < SYNC; k++) begin
                wrGraySync_q[k] <= '0;
            end
        end else begin
            wrGraySync_q[0] <= wrPtrGray_q;
            for (int k = 1; k < SYNC; k++) begin
                wrGraySync_q[k] <= wrGraySync_q[k-1];
            end
        end
    end

    // Read-side pointers and the output-valid flag
    always_ff @(posedge o_clk or negedge o_rstn) begin
        if (!o_rstn) begin
            popPtrBin_q  <= '0;
            popPtrGray_q <= '0;
            rdAddr_q     <= '0;
            outValid_q   <= 1'b0;
        end else begin
            popPtrBin_q  <= popPtrBin_d;
            popPtrGray_q <= bin2gray(popPtrBin_d);
            rdAddr_q     <= rdAddr_d;
            outValid_q   <= outValid_d;
        end
    end

    // The output word changes only on a load, so it holds while the consumer stalls
    always_ff @(posedge o_clk) begin
        if (load) begin
            outData_q <= mem[rdAddr_q[EA-1:0]];
        end
    end

    assign o_tvalid = outValid_q;
    assign o_tdata  = outData_q;

`ifdef FIFO_ASYNC_LEVEL_EN
    logic [EA:0] rdSyncBin;
    logic [EA:0] wrLevel_d;
    logic [EA:0] wrLevel_q;
    logic        wrAfull_q;
    logic [EA:0] rdLevel_d;
    logic [EA:0] rdLevel_q;
    logic        rdAempty_q;

    // The write side uses the next write pointer and a stale consumed pointer,
    // so its count can only over-report. The read side uses a stale write
    // pointer and the next popped pointer, so its count can only under-report.
    // Modular subtraction keeps both counts correct across pointer wrap.
    assign rdSyncBin = gray2bin(rdGraySync_q[SYNC-1]);
    assign wrLevel_d = wrPtrBin_d - rdSyncBin;
    assign rdLevel_d = wrSyncBin - popPtrBin_d;

    // Registered write-side fill count and almost-full flag
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wrLevel_q <= '0;
            wrAfull_q <= 1'b0;
        end else begin
            wrLevel_q <= wrLevel_d;
            wrAfull_q <= (int'(wrLevel_d) >= AFULL_TH);
        end
    end

    // Registered read-side fill count (including the presented word) and almost-empty flag
    always_ff @(posedge o_clk or negedge o_rstn) begin
        if (!o_rstn) begin
            rdLevel_q  <= '0;
            rdAempty_q <= 1'b1;
        end else begin
            rdLevel_q  <= rdLevel_d;
            rdAempty_q <= (int'(rdLevel_d) <= AEMPTY_TH);
        end
    end

    assign i_level  = wrLevel_q;
    assign i_afull  = wrAfull_q;
    assign o_level  = rdLevel_q;
    assign o_aempty = rdAempty_q;
`else
    logic unusedLevelCfg;
    assign unusedLevelCfg = (AFULL_TH != AEMPTY_TH);

    assign i_level  = '0;
    assign i_afull  = 1'b0;
    assign o_level  = '0;
    assign o_aempty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_async_level.sv
// Self-checking bench for fifo_async_level. It uses a small instance
// (EA=2, depth 4) so that fill, wrap and flush are reached quickly. Expectations
// for the level ports follow FIFO_ASYNC_LEVEL_EN: the true counts when the
// macro is defined, constant zero otherwise.
module tb_fifo_async_level;

    localparam int Dw       = 8;
    localparam int Ea       = 2;
    localparam int Sync     = 2;
    localparam int Depth    = 1 << Ea;
    localparam int AfullTh  = 4;
    localparam int AemptyTh = 2;
`ifdef FIFO_ASYNC_LEVEL_EN
    localparam bit LevelEn = 1'b1;
`else
    localparam bit LevelEn = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          o_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          o_rstn = 1'b0;
    logic          i_tready;
    logic          i_tvalid = 1'b0;
    logic [Dw-1:0] i_tdata = '0;
    logic [Ea:0]   i_level;
    logic          i_afull;
    logic          o_tready = 1'b0;
    logic          o_tvalid;
    logic [Dw-1:0] o_tdata;
    logic [Ea:0]   o_level;
    logic          o_aempty;

    int errors = 0;
    int checks = 0;
    int wrCount = 0;
    int rdCount = 0;
    logic [Dw-1:0] model [$];

    fifo_async_level #(
        .DW(Dw), .EA(Ea), .SYNC(Sync), .AFULL_TH(AfullTh), .AEMPTY_TH(AemptyTh)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .o_clk(o_clk), .o_rstn(o_rstn),
        .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
        .i_level(i_level), .i_afull(i_afull),
        .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata),
        .o_level(o_level), .o_aempty(o_aempty)
    );

    // 100 MHz write clock and roughly 33 MHz read clock. The read clock is
    // offset so that its edges never coincide with write-clock edges.
    always #5 i_clk = ~i_clk;
    initial begin
        #2;
        forever #15 o_clk = ~o_clk;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyReset();
        i_rstn = 1'b0;
        o_rstn = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        i_tdata = '0;
        model.delete();
        wrCount = 0;
        rdCount = 0;
        #40;
    endtask

    task automatic releaseReset();
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge o_clk);
        o_rstn = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    // Reset values on both sides, then i_tready after release
    task automatic test_reset();
        applyReset();
        checks++;
        if (o_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_tvalid: got %b want 0", o_tvalid); end
        checks++;
        if (i_level !== '0) begin errors++; $display("[TB] FAIL reset_i_level: got %0d want 0", i_level); end
        checks++;
        if (i_afull !== 1'b0) begin errors++; $display("[TB] FAIL reset_i_afull: got %b want 0", i_afull); end
        checks++;
        if (o_level !== '0) begin errors++; $display("[TB] FAIL reset_o_level: got %0d want 0", o_level); end
        checks++;
        if (o_aempty !== LevelEn) begin errors++; $display("[TB] FAIL reset_o_aempty: got %b want %b", o_aempty, LevelEn); end
        releaseReset();
        checks++;
        if (i_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_i_tready: got %b want 1", i_tready); end
    endtask

    // Fill with the reader stalled: exactly Depth words accepted. Then drain at full rate.
    task automatic test_fill_full();
        int accepted = 0;
        int expLevel;
        o_tready = 1'b0;
        for (int k = 0; k < Depth + 2; k++) begin
            logic acc;
            @(negedge i_clk);
            i_tvalid = 1'b1;
            i_tdata = Dw'(32'hA0 + k);
            acc = i_tready;
            @(posedge i_clk);
            if (acc) begin model.push_back(i_tdata); accepted++; end
        end
        @(negedge i_clk);
        i_tvalid = 1'b0;
        checks++;
        if (accepted != Depth) begin errors++; $display("[TB] FAIL fill_accepted: got %0d want %0d", accepted, Depth); end
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("[TB] FAIL fill_i_tready: got %b want 0", i_tready); end
        checks++;
        expLevel = LevelEn ? Depth : 0;
        if (int'(i_level) != expLevel) begin errors++; $display("[TB] FAIL fill_i_level: got %0d want %0d", i_level, expLevel); end
        checks++;
        if (i_afull !== (LevelEn && (Depth >= AfullTh))) begin
            errors++; $display("[TB] FAIL fill_i_afull: got %b want %b", i_afull, LevelEn && (Depth >= AfullTh));
        end
        repeat (Sync + 4) @(negedge o_clk);
        checks++;
        if (o_aempty !== 1'b0) begin errors++; $display("[TB] FAIL fill_o_aempty: got %b want 0", o_aempty); end
        o_tready = 1'b1;
        for (int k = 0; k < Depth; k++) begin
            expLevel = LevelEn ? (Depth - k) : 0;
            checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== Dw'(32'hA0 + k)) begin
                errors++; $display("[TB] FAIL drain_word%0d: got valid=%b data=%h want valid=1 data=%h", k, o_tvalid, o_tdata, Dw'(32'hA0 + k));
            end
            checks++;
            if (int'(o_level) != expLevel) begin errors++; $display("[TB] FAIL drain_o_level%0d: got %0d want %0d", k, o_level, expLevel); end
            checks++;
            if (o_aempty !== (LevelEn && ((Depth - k) <= AemptyTh))) begin
                errors++; $display("[TB] FAIL drain_o_aempty%0d: got %b want %b", k, o_aempty, LevelEn && ((Depth - k) <= AemptyTh));
            end
            @(posedge o_clk);
            if (model.size() != 0) void'(model.pop_front());
            @(negedge o_clk);
        end
        o_tready = 1'b0;
        checks++;
        if (o_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty_valid: got %b want 0", o_tvalid); end
        checks++;
        if (o_level !== '0) begin errors++; $display("[TB] FAIL drain_o_level_end: got %0d want 0", o_level); end
        repeat (Sync + 4) @(negedge i_clk);
        checks++;
        if (i_level !== '0 || i_afull !== 1'b0 || i_tready !== 1'b1) begin
            errors++; $display("[TB] FAIL drain_write_side: got level=%0d afull=%b ready=%b want 0 0 1", i_level, i_afull, i_tready);
        end
    endtask

    // A single word becomes visible only after it has passed the synchroniser, and within SYNC+3 read edges
    task automatic test_first_word();
        int edges = 0;
        bit seen = 0;
        @(negedge i_clk);
        i_tvalid = 1'b1;
        i_tdata = Dw'(32'h11);
        @(posedge i_clk);
        #1 i_tvalid = 1'b0;
        while (!seen && edges < Sync + 6) begin
            @(posedge o_clk);
            edges++;
            #1;
            if (o_tvalid === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || edges < Sync + 1 || edges > Sync + 3) begin
            errors++; $display("[TB] FAIL first_latency: got seen=%0d edges=%0d want %0d..%0d", seen, edges, Sync + 1, Sync + 3);
        end
        checks++;
        if (o_tdata !== Dw'(32'h11)) begin errors++; $display("[TB] FAIL first_data: got %h want 11", o_tdata); end
        checks++;
        if (int'(o_level) != (LevelEn ? 1 : 0)) begin errors++; $display("[TB] FAIL first_o_level: got %0d want %0d", o_level, LevelEn ? 1 : 0); end
        checks++;
        if (o_aempty !== LevelEn) begin errors++; $display("[TB] FAIL first_o_aempty: got %b want %b", o_aempty, LevelEn); end
        @(negedge o_clk);
        o_tready = 1'b1;
        @(posedge o_clk);
        #1 o_tready = 1'b0;
        checks++;
        if (o_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL first_pop: got valid=%b want 0", o_tvalid); end
    endtask

    task automatic streamWriter(input int n, input int validPct);
        int guard = 0;
        int sent = 0;
        while (sent < n && guard < 40 * n + 1000) begin
            logic acc;
            int lo;
            int hi;
            @(negedge i_clk);
            guard++;
            lo = LevelEn ? (wrCount - rdCount) : 0;
            hi = LevelEn ? Depth : 0;
            checks++;
            if (int'(i_level) < lo || int'(i_level) > hi) begin
                errors++; $display("[TB] FAIL stream_i_level: got %0d want %0d..%0d", i_level, lo, hi);
            end
            i_tvalid = ($urandom_range(99) < validPct);
            i_tdata = Dw'($urandom);
            acc = i_tvalid & i_tready;
            @(posedge i_clk);
            if (acc) begin model.push_back(i_tdata); wrCount++; sent++; end
        end
        @(negedge i_clk);
        i_tvalid = 1'b0;
        checks++;
        if (sent != n) begin errors++; $display("[TB] FAIL stream_writer_timeout: got %0d words want %0d", sent, n); end
    endtask

    task automatic streamReader(input int n, input int readyPct);
        int guard = 0;
        bit holding = 0;
        logic [Dw-1:0] heldData = '0;
        while (rdCount < n && guard < 120 * n + 1000) begin
            bit willPop;
            int hi;
            @(negedge o_clk);
            guard++;
            hi = LevelEn ? (wrCount - rdCount) : 0;
            checks++;
            if (int'(o_level) > hi) begin errors++; $display("[TB] FAIL stream_o_level: got %0d want <=%0d", o_level, hi); end
            if (holding) begin
                checks++;
                if (o_tvalid !== 1'b1 || o_tdata !== heldData) begin
                    errors++; $display("[TB] FAIL stream_hold: got valid=%b data=%h want 1 %h", o_tvalid, o_tdata, heldData);
                end
            end
            o_tready = ($urandom_range(99) < readyPct);
            willPop = (o_tvalid === 1'b1) && (o_tready === 1'b1);
            holding = (o_tvalid === 1'b1) && (o_tready !== 1'b1);
            heldData = o_tdata;
            if (willPop) begin
                checks++;
                if (model.size() == 0) begin
                    errors++; $display("[TB] FAIL stream_spurious: got data=%h want no word", o_tdata);
                end else if (o_tdata !== model[0]) begin
                    errors++; $display("[TB] FAIL stream_data%0d: got %h want %h", rdCount, o_tdata, model[0]);
                end
            end
            @(posedge o_clk);
            if (willPop) begin
                if (model.size() != 0) void'(model.pop_front());
                rdCount++;
            end
        end
        @(negedge o_clk);
        o_tready = 1'b0;
        checks++;
        if (rdCount != n) begin errors++; $display("[TB] FAIL stream_reader_timeout: got %0d words want %0d", rdCount, n); end
    endtask

    // Random or continuous traffic through both domains against the queue model
    task automatic test_stream(input int n, input int validPct, input int readyPct);
        wrCount = 0;
        rdCount = 0;
        model.delete();
        fork
            streamWriter(n, validPct);
            streamReader(n, readyPct);
        join
        repeat (Sync + 4) @(negedge o_clk);
        checks++;
        if (o_tvalid !== 1'b0 || model.size() != 0) begin
            errors++; $display("[TB] FAIL stream_leftover: got valid=%b model=%0d want 0 0", o_tvalid, model.size());
        end
    endtask

    // Flush both sides with words stored; the next word written must come out first
    task automatic test_flush();
        int waitCycles = 0;
        o_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            i_tvalid = 1'b1;
            i_tdata = Dw'(32'hC0 + k);
            @(posedge i_clk);
        end
        @(negedge i_clk);
        i_tvalid = 1'b0;
        repeat (Sync + 4) @(negedge o_clk);
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== Dw'(32'hC0)) begin
            errors++; $display("[TB] FAIL flush_prefill: got valid=%b data=%h want 1 c0", o_tvalid, o_tdata);
        end
        i_rstn = 1'b0;
        o_rstn = 1'b0;
        #20;
        checks++;
        if (o_tvalid !== 1'b0 || i_level !== '0 || o_level !== '0 || i_tready !== 1'b1 || i_afull !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_state: got valid=%b il=%0d ol=%0d ready=%b afull=%b want 0 0 0 1 0",
                               o_tvalid, i_level, o_level, i_tready, i_afull);
        end
        checks++;
        if (o_aempty !== LevelEn) begin errors++; $display("[TB] FAIL flush_o_aempty: got %b want %b", o_aempty, LevelEn); end
        model.delete();
        wrCount = 0;
        rdCount = 0;
        releaseReset();
        @(negedge i_clk);
        i_tvalid = 1'b1;
        i_tdata = Dw'(32'h5A);
        @(posedge i_clk);
        #1 i_tvalid = 1'b0;
        while (o_tvalid !== 1'b1 && waitCycles < 12) begin
            @(negedge o_clk);
            waitCycles++;
        end
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== Dw'(32'h5A)) begin
            errors++; $display("[TB] FAIL flush_next_word: got valid=%b data=%h want 1 5a", o_tvalid, o_tdata);
        end
        @(negedge o_clk);
        o_tready = 1'b1;
        @(posedge o_clk);
        #1 o_tready = 1'b0;
        repeat (Sync + 4) @(negedge o_clk);
        checks++;
        if (o_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL flush_stale: got valid=%b want 0", o_tvalid); end
    endtask

    initial begin
        $display("[TB] fifo_async_level bench, level logic enabled=%0d", LevelEn);
        test_reset();
        test_fill_full();
        test_first_word();
        test_stream(2000, 60, 50);
        test_stream(3 * 2 * Depth, 100, 100);
        test_stream(400, 25, 90);
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
